// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter slice: ALU control codes, FSM states
// and the op-code legality helper.
package alu_defs;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SLL = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // 3'b101 is the only hole in the ALU control map.
  function automatic logic is_legal_op(input logic [2:0] op);
    logic legal;
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SLL,
      ALU_NOR, ALU_SUB, ALU_SLT: legal = 1'b1;
      default:                   legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response handshake bundle between the two requesters and the arbiter.
interface alu_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 3
);
  logic              req_valid_0, req_valid_1;
  logic              req_ready_0, req_ready_1;
  logic [DATA_W-1:0] req_a_0, req_a_1;
  logic [DATA_W-1:0] req_b_0, req_b_1;
  logic [OP_W-1:0]   req_op_0, req_op_1;
  logic              rsp_valid_0, rsp_valid_1;
  logic              rsp_ready_0, rsp_ready_1;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero;
  logic              rsp_err;

  modport master (
    output req_valid_0, req_valid_1, req_a_0, req_a_1, req_b_0, req_b_1,
           req_op_0, req_op_1, rsp_ready_0, rsp_ready_1,
    input  req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1,
           rsp_result, rsp_zero, rsp_err
  );

  modport slave (
    input  req_valid_0, req_valid_1, req_a_0, req_a_1, req_b_0, req_b_1,
           req_op_0, req_op_1, rsp_ready_0, rsp_ready_1,
    output req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1,
           rsp_result, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu32.sv
// Combinational 32-bit ALU shared by the arbiter's requesters.
// SLL shifts b left by a[4:0]; SLT is a signed compare.
module alu32
  import alu_defs::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  gin,
  output logic [31:0] sum,
  output logic        zout
);

  // Operation select and zero detect.
  always_comb begin
    sum = 32'd0;
    case (gin)
      ALU_AND: sum = a & b;
      ALU_OR:  sum = a | b;
      ALU_ADD: sum = a + b;
      ALU_SLL: sum = b << a[4:0];
      ALU_NOR: sum = ~(a | b);
      ALU_SUB: sum = a - b;
      ALU_SLT: sum = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: sum = 32'd0;
    endcase
    zout = (sum == 32'd0);
  end

endmodule

// File: rtl/alu_arbiter_rr.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to the
// pointer, and every grant hands priority to the other side.
module rr_grant2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  logic ptr_q, ptr_d;

  // Winner selection and pointer update.
  always_comb begin
    if (req == 2'b11) begin
      gnt_idx = ptr_q;
    end else if (req[1]) begin
      gnt_idx = 1'b1;
    end else begin
      gnt_idx = 1'b0;
    end

    if (en && (req != 2'b00)) begin
      gnt   = gnt_idx ? 2'b10 : 2'b01;
      ptr_d = ~gnt_idx;
    end else begin
      gnt   = 2'b00;
      ptr_d = ptr_q;
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters: accept (IDLE), let the ALU
// settle on registered operands (EXEC), then hold the result until consumed (RESP).
module alu_arbiter
  import alu_defs::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
  alu_arbiter_if.slave      bus,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_gin,
  input  logic [DATA_W-1:0] alu_sum,
  input  logic              alu_zout
);

  state_e            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              ill_q, ill_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [OP_W-1:0]   alu_gin_q, alu_gin_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic              rsp_zero_q, rsp_zero_d;
  logic              rsp_err_q, rsp_err_d;

  logic              arb_en_s;
  logic [1:0]        gnt_s;
  logic              gnt_idx_s;
  logic [DATA_W-1:0] sel_a_s, sel_b_s;
  logic [OP_W-1:0]   sel_op_s;
  logic              rsp_ready_sel_s;

  // Arbitration only runs in IDLE and never while reset is asserted.
  assign arb_en_s = (state_q == ST_IDLE) && !reset;

  rr_grant2 u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     ({bus.req_valid_1, bus.req_valid_0}),
    .en      (arb_en_s),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s)
  );

  assign sel_a_s         = gnt_idx_s ? bus.req_a_1  : bus.req_a_0;
  assign sel_b_s         = gnt_idx_s ? bus.req_b_1  : bus.req_b_0;
  assign sel_op_s        = gnt_idx_s ? bus.req_op_1 : bus.req_op_0;
  assign rsp_ready_sel_s = gnt_q ? bus.rsp_ready_1 : bus.rsp_ready_0;

  // Next-state and registered-output computation for the sequencer.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    ill_d        = ill_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_gin_d    = alu_gin_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (gnt_s != 2'b00) begin
          gnt_d   = gnt_idx_s;
          alu_a_d = sel_a_s;
          alu_b_d = sel_b_s;
          // An illegal code still runs, but through a harmless ADD.
          if (is_legal_op(sel_op_s)) begin
            ill_d     = 1'b0;
            alu_gin_d = sel_op_s;
          end else begin
            ill_d     = 1'b1;
            alu_gin_d = ALU_ADD;
          end
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (ill_q) begin
          rsp_result_d = '0;
          rsp_zero_d   = 1'b1;
          rsp_err_d    = 1'b1;
        end else begin
          rsp_result_d = alu_sum;
          rsp_zero_d   = alu_zout;
          rsp_err_d    = 1'b0;
        end
        rsp_valid_d = gnt_q ? 2'b10 : 2'b01;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready_sel_s) begin
          rsp_valid_d = 2'b00;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        rsp_valid_d = 2'b00;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // Sequencer state and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      gnt_q        <= 1'b0;
      ill_q        <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_gin_q    <= ALU_ADD;
      rsp_valid_q  <= 2'b00;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      ill_q        <= ill_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_gin_q    <= alu_gin_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign bus.req_ready_0 = gnt_s[0];
  assign bus.req_ready_1 = gnt_s[1];
  assign bus.rsp_valid_0 = rsp_valid_q[0];
  assign bus.rsp_valid_1 = rsp_valid_q[1];
  assign bus.rsp_result  = rsp_result_q;
  assign bus.rsp_zero    = rsp_zero_q;
  assign bus.rsp_err     = rsp_err_q;
  assign alu_a           = alu_a_q;
  assign alu_b           = alu_b_q;
  assign alu_gin         = alu_gin_q;

endmodule
